// File: rtl/mem_ctrl_if.sv
// ============================================================================
// Module      : mem_ctrl_if
// Description : Signal bundle for the BRAM initiator-side controller.
//               Groups the core request/response streams, the clear/busy
//               control pair and the BRAM port into one interface.
//   slave  modport : controller view (drives ready/response/BRAM port)
//   master modport : environment view (core + BRAM drive the rest)
// Signals:
//   req_valid_i / req_ready_o        request handshake
//   req_we_i, req_addr_i[13:0],
//   req_wdata_i[31:0]                request payload (1 = write)
//   rsp_valid_o / rsp_ready_i        read response handshake
//   rsp_rdata_o[31:0]                read data (FIFO head)
//   clear_i / busy_o                 zero-fill start pulse / in-progress flag
//   bram_en_o, bram_we_o,
//   bram_addr_o[13:0], bram_d_o[31:0] BRAM port command
//   bram_d_i[31:0]                   BRAM registered read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [13:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        clear_i;
  logic        busy_o;
  logic        bram_en_o;
  logic        bram_we_o;
  logic [13:0] bram_addr_o;
  logic [31:0] bram_d_o;
  logic [31:0] bram_d_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i, clear_i, bram_d_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o,
    output bram_en_o, bram_we_o, bram_addr_o, bram_d_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output rsp_ready_i, clear_i, bram_d_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o,
    input  bram_en_o, bram_we_o, bram_addr_o, bram_d_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Initiator-side controller for a single-port 32-bit BRAM.
//               Converts a valid/ready read/write request stream into BRAM
//               port cycles, returns read data through a response FIFO so
//               core backpressure never loses data, and offers a hardware
//               zero-fill sequence of MEM_WORDS words.
// Ports:
//   clk_i   : clock, all logic on the rising edge
//   rst_ni  : synchronous active-low reset
//   bus     : mem_ctrl_if.slave (request, response, clear/busy, BRAM port)
// Parameters:
//   MEM_WORDS : words swept by the clear sequence
//   RSP_DEPTH : response FIFO entries (>= 3 for one read per cycle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl #(
  parameter int MEM_WORDS = 64,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  mem_ctrl_if.slave   bus
);

  localparam int c_ptr_w = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(RSP_DEPTH + 1);

  localparam logic [13:0]        c_last_addr = 14'(MEM_WORDS - 1);
  localparam logic [c_cnt_w:0]   c_depth     = (c_cnt_w + 1)'(RSP_DEPTH);
  localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(RSP_DEPTH - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                r_inflight;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [13:0]         r_clr_cnt;
  logic [31:0]         r_fifo [RSP_DEPTH];

  logic                w_req_ready;
  logic                w_accept;
  logic                w_read_issue;
  logic                w_bram_en;
  logic                w_bram_we;
  logic [13:0]         w_bram_addr;
  logic [31:0]         w_bram_d;
  logic                w_busy;
  logic                w_rsp_valid;
  logic                w_push;
  logic                w_pop;
  logic [c_cnt_w:0]    w_occupancy;
  logic                w_credit_ok;

  // Credits: entries already queued plus the read whose data is still in the
  // BRAM pipeline must leave room, so a push can never hit a full FIFO.
  assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_credit_ok = (w_occupancy < c_depth);

  assign w_rsp_valid = (r_count != '0);
  assign w_push      = r_inflight;
  assign w_pop       = w_rsp_valid && bus.rsp_ready_i;

  // --------------------------------------------------------------------------
  // Next-state and BRAM port decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_accept     = 1'b0;
    w_bram_en    = 1'b0;
    w_bram_we    = 1'b0;
    w_bram_addr  = '0;
    w_bram_d     = '0;
    w_busy       = 1'b0;

    case (r_state)
      IDLE: begin
        // clear_i wins over a simultaneous request; the request waits until
        // the sweep is over.
        w_req_ready = w_credit_ok && !bus.clear_i;
        w_accept    = bus.req_valid_i && w_req_ready;
        if (w_accept) begin
          w_bram_en   = 1'b1;
          w_bram_we   = bus.req_we_i;
          w_bram_addr = bus.req_addr_i;
          w_bram_d    = bus.req_wdata_i;
        end
        if (bus.clear_i) begin
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        w_busy      = 1'b1;
        w_bram_en   = 1'b1;
        w_bram_we   = 1'b1;
        w_bram_addr = r_clr_cnt;
        w_bram_d    = '0;
        if (r_clr_cnt == c_last_addr) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Nothing may reach the BRAM or the core while reset is held.
    if (!rst_ni) begin
      w_req_ready = 1'b0;
      w_accept    = 1'b0;
      w_bram_en   = 1'b0;
      w_bram_we   = 1'b0;
    end
  end

  assign w_read_issue = w_accept && !bus.req_we_i;

  // --------------------------------------------------------------------------
  // State, credit and FIFO bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_clr_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_read_issue;

      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase

      if (r_state == CLEAR) begin
        r_clr_cnt <= (r_clr_cnt == c_last_addr) ? '0 : r_clr_cnt + 14'd1;
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by r_count. Data from
  // a read that was in flight when reset arrived is dropped here.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_push) begin
      r_fifo[r_wr_ptr] <= bus.bram_d_i;
    end
  end

  assign bus.req_ready_o = w_req_ready;
  assign bus.rsp_valid_o = w_rsp_valid;
  assign bus.rsp_rdata_o = r_fifo[r_rd_ptr];
  assign bus.busy_o      = w_busy;
  assign bus.bram_en_o   = w_bram_en;
  assign bus.bram_we_o   = w_bram_we;
  assign bus.bram_addr_o = w_bram_addr;
  assign bus.bram_d_o    = w_bram_d;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl. Models a 64-word
//               BRAM with one-cycle registered read data and drives the core
//               side from a single linear stimulus sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_acc;

  logic [31:0] bram_model [0:63];

  mem_ctrl_if bus ();

  mem_ctrl #(
    .MEM_WORDS (64),
    .RSP_DEPTH (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: write on enable+we, registered read data one cycle after enable.
  always @(posedge clk) begin
    if (bus.bram_en_o) begin
      if (bus.bram_we_o) begin
        bram_model[bus.bram_addr_o[5:0]] <= bus.bram_d_o;
      end else begin
        bus.bram_d_i <= bram_model[bus.bram_addr_o[5:0]];
      end
    end
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.clear_i     = 1'b0;
  endtask

  // Called at a falling edge; issues one write and returns at the next one.
  task automatic do_write(input logic [13:0] a, input logic [31:0] d);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    #1;
    check_bit ("wr_ready", bus.req_ready_o, 1'b1);
    check_bit ("wr_en",    bus.bram_en_o,   1'b1);
    check_bit ("wr_we",    bus.bram_we_o,   1'b1);
    check_word("wr_addr",  32'(bus.bram_addr_o), 32'(a));
    check_word("wr_data",  bus.bram_d_o,    d);
    @(negedge clk);
    idle_inputs();
  endtask

  // Called at a falling edge; presents a read for one cycle.
  task automatic do_read(input logic [13:0] a);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = a;
    #1;
    check_bit ("rd_ready", bus.req_ready_o, 1'b1);
    check_bit ("rd_en",    bus.bram_en_o,   1'b1);
    check_bit ("rd_we",    bus.bram_we_o,   1'b0);
    check_word("rd_addr",  32'(bus.bram_addr_o), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    n_acc  = 0;
    idle_inputs();
    bus.rsp_ready_i = 1'b0;
    rst_n = 1'b0;

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    bus.req_valid_i = 1'b1;
    #1;
    check_bit("rst_ready_forced", bus.req_ready_o, 1'b0);
    check_bit("rst_en_forced",    bus.bram_en_o,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    check_bit("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check_bit("rst_busy",      bus.busy_o,      1'b0);
    check_bit("rst_ready",     bus.req_ready_o, 1'b1);
    check_bit("rst_idle_en",   bus.bram_en_o,   1'b0);
    @(negedge clk);

    // ---------------- write then read addr 5 ----------------
    do_write(14'd5, 32'hDEADBEEF);
    do_read(14'd5);
    @(negedge clk);
    idle_inputs();
    #1;
    check_bit("t1_n1_valid", bus.rsp_valid_o, 1'b0);
    check_bit("t1_n1_en",    bus.bram_en_o,   1'b0);
    @(negedge clk);
    #1;
    check_bit ("t1_n2_valid", bus.rsp_valid_o, 1'b1);
    check_word("t1_n2_data",  bus.rsp_rdata_o, 32'hDEADBEEF);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    #1;
    check_bit("t1_single", bus.rsp_valid_o, 1'b0);
    @(negedge clk);

    // ---------------- back-to-back reads 0..7 ----------------
    for (int i = 0; i < 8; i++) do_write(14'(i), 32'(i * 3));
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        do_read(14'(i));
      end else begin
        idle_inputs();
        #1;
      end
      if (i >= 2) begin
        check_bit ("b2b_valid", bus.rsp_valid_o, 1'b1);
        check_word("b2b_data",  bus.rsp_rdata_o, 32'((i - 2) * 3));
      end
      @(negedge clk);
    end
    #1;
    check_bit("b2b_drained", bus.rsp_valid_o, 1'b0);
    @(negedge clk);

    // ---------------- backpressure: credits for 4 reads ----------------
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = 14'(1 + n_acc);
      #1;
      check_bit("bp_ready", bus.req_ready_o, (i < 4) ? 1'b1 : 1'b0);
      if (i >= 4) begin
        check_bit ("bp_hold_valid", bus.rsp_valid_o, 1'b1);
        check_word("bp_hold_data",  bus.rsp_rdata_o, 32'd3);
      end
      if (bus.req_ready_o) n_acc++;
      @(negedge clk);
    end
    check_word("bp_accepted", 32'(n_acc), 32'd4);
    idle_inputs();
    bus.rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_bit ("bp_valid", bus.rsp_valid_o, 1'b1);
      check_word("bp_data",  bus.rsp_rdata_o, 32'((k + 1) * 3));
      check_bit ("bp_ready_back", bus.req_ready_o, (k != 0) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    #1;
    check_bit("bp_drained", bus.rsp_valid_o, 1'b0);
    @(negedge clk);

    // ---------------- fill, then clear with a colliding request ----------------
    for (int i = 0; i < 64; i++) do_write(14'(i), 32'hFFFFFFFF);
    bus.clear_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 14'd10;
    #1;
    check_bit("clr_start_ready", bus.req_ready_o, 1'b0);
    check_bit("clr_start_en",    bus.bram_en_o,   1'b0);
    check_bit("clr_start_busy",  bus.busy_o,      1'b0);
    @(negedge clk);
    bus.clear_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      check_bit ("clr_busy",  bus.busy_o,      1'b1);
      check_bit ("clr_ready", bus.req_ready_o, 1'b0);
      check_bit ("clr_en",    bus.bram_en_o,   1'b1);
      check_bit ("clr_we",    bus.bram_we_o,   1'b1);
      check_word("clr_addr",  32'(bus.bram_addr_o), 32'(i));
      check_word("clr_data",  bus.bram_d_o,    32'h0);
      @(negedge clk);
    end
    #1;
    check_bit("clr_done_busy", bus.busy_o, 1'b0);
    // Held request (addr 10) is accepted as soon as the sweep ends.
    do_read(14'd10);
    @(negedge clk);
    do_read(14'd0);
    @(negedge clk);
    do_read(14'd31);
    check_bit ("clr_rd10_valid", bus.rsp_valid_o, 1'b1);
    check_word("clr_rd10_data",  bus.rsp_rdata_o, 32'h0);
    @(negedge clk);
    do_read(14'd63);
    check_bit ("clr_rd0_valid", bus.rsp_valid_o, 1'b1);
    check_word("clr_rd0_data",  bus.rsp_rdata_o, 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check_bit ("clr_rd31_valid", bus.rsp_valid_o, 1'b1);
    check_word("clr_rd31_data",  bus.rsp_rdata_o, 32'h0);
    @(negedge clk);
    #1;
    check_bit ("clr_rd63_valid", bus.rsp_valid_o, 1'b1);
    check_word("clr_rd63_data",  bus.rsp_rdata_o, 32'h0);
    @(negedge clk);
    #1;
    check_bit("clr_drained", bus.rsp_valid_o, 1'b0);
    @(negedge clk);

    // ---------------- reset with 2 queued + 1 inflight ----------------
    do_write(14'd40, 32'hA5A50040);
    do_write(14'd41, 32'hA5A50041);
    do_write(14'd42, 32'hA5A50042);
    do_write(14'd43, 32'hA5A50043);
    bus.rsp_ready_i = 1'b0;
    do_read(14'd40);
    @(negedge clk);
    do_read(14'd41);
    @(negedge clk);
    do_read(14'd42);
    @(negedge clk);
    idle_inputs();
    #1;
    check_bit ("mr_pre_valid", bus.rsp_valid_o, 1'b1);
    check_word("mr_pre_data",  bus.rsp_rdata_o, 32'hA5A50040);
    rst_n = 1'b0;
    bus.req_valid_i = 1'b1;
    #1;
    check_bit("mr_ready_forced", bus.req_ready_o, 1'b0);
    check_bit("mr_en_forced",    bus.bram_en_o,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_bit("mr_no_stale", bus.rsp_valid_o, 1'b0);
      check_bit("mr_busy",     bus.busy_o,      1'b0);
      @(negedge clk);
    end
    do_read(14'd43);
    @(negedge clk);
    idle_inputs();
    #1;
    check_bit("mr_rd_n1", bus.rsp_valid_o, 1'b0);
    @(negedge clk);
    #1;
    check_bit ("mr_rd_valid", bus.rsp_valid_o, 1'b1);
    check_word("mr_rd_data",  bus.rsp_rdata_o, 32'hA5A50043);
    @(negedge clk);
    #1;
    check_bit("mr_rd_single", bus.rsp_valid_o, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
